// File: rtl/fortress_pkg.sv
// Shared types and helpers for the two-tank artillery game controller.
package fortress_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AIM,
      S_CHARGE,
      S_FLIGHT,
      S_IMPACT,
      S_OVER
   } state_t;

   localparam logic [2:0] TANK1_POS = 3'd0;
   localparam logic [2:0] TANK2_POS = 3'd7;

   function automatic logic [7:0] therm(input logic [3:0] n);
      logic [8:0] t;
      t = (9'd1 << n) - 9'd1;
      return t[7:0];
   endfunction

   // n is the distance flown from the shooter; beyond the field shows nothing
   function automatic logic [7:0] cell_onehot(input logic t, input logic [3:0] n);
      logic [3:0] pos;
      pos = '0;
      if (n > 4'd7) return 8'd0;
      pos = t ? ({1'b0, TANK2_POS} - n) : ({1'b0, TANK1_POS} + n);
      return 8'd1 << pos[2:0];
   endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Key inputs and game outputs of the turn sequencer.
interface turn_sequencer_if;
   logic       tick;
   logic       key_4;
   logic       key_5;
   logic       key_6;
   logic       turn;
   logic [7:0] power;
   logic       fire;
   logic [7:0] SHELL;
   logic [1:0] tank1_life;
   logic [1:0] tank2_life;
   logic       hit;
   logic       game_over;

   modport master (
      output tick, key_4, key_5, key_6,
      input  turn, power, fire, SHELL,
      input  tank1_life, tank2_life, hit, game_over
   );

   modport slave (
      input  tick, key_4, key_5, key_6,
      output turn, power, fire, SHELL,
      output tank1_life, tank2_life, hit, game_over
   );
endinterface

// File: rtl/key_edge.sv
// Registers a debounced key level and emits 1-cycle rise/fall pulses.
module key_edge (
   input  logic clk,
   input  logic nrst,
   input  logic key,
   output logic rise,
   output logic fall
);
   logic lvl;
   logic prev;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         lvl  <= 1'b0;
         prev <= 1'b0;
      end else begin
         lvl  <= key;
         prev <= lvl;
      end
   end

   assign rise = lvl & ~prev;
   assign fall = ~lvl & prev;
endmodule

// File: rtl/turn_sequencer.sv
// Game-flow FSM: turn order, power charge, shell flight, hits, lives.
module turn_sequencer #(
   parameter int MAX_POWER    = 8,
   parameter int TANK_DIST    = 7,
   parameter int FLIGHT_DIV   = 4,
   parameter int IMPACT_TICKS = 16,
   parameter int LIVES        = 3
) (
   input logic             clk,
   input logic             nrst,
   turn_sequencer_if.slave bus
);
   import fortress_pkg::*;

   logic k4_rise, k4_fall;
   logic k5_rise, k5_fall;
   logic k6_rise, k6_fall;
   logic unused_falls;

   key_edge u_k4 (.clk(clk), .nrst(nrst), .key(bus.key_4),
                  .rise(k4_rise), .fall(k4_fall));
   key_edge u_k5 (.clk(clk), .nrst(nrst), .key(bus.key_5),
                  .rise(k5_rise), .fall(k5_fall));
   key_edge u_k6 (.clk(clk), .nrst(nrst), .key(bus.key_6),
                  .rise(k6_rise), .fall(k6_fall));

   assign unused_falls = k5_fall | k6_fall;

   state_t     state;
   logic [3:0] power_lvl;
   logic [3:0] range_q;
   logic [3:0] step;
   logic [4:0] tick_cnt;
   logic       turn_q;
   logic       fire_q;
   logic       hit_q;
   logic       over_q;
   logic [7:0] power_q;
   logic [7:0] shell_q;
   logic [1:0] life1;
   logic [1:0] life2;

   logic [3:0] step_nx;
   logic [3:0] power_nx;
   logic [1:0] opp_life;

   assign step_nx  = step + 4'd1;
   assign power_nx = (power_lvl == 4'(MAX_POWER)) ? 4'd1 : power_lvl + 4'd1;
   assign opp_life = turn_q ? life1 : life2;

   always_ff @(posedge clk) begin
      if (!nrst || k6_rise) begin
         state     <= S_IDLE;
         power_lvl <= '0;
         range_q   <= '0;
         step      <= '0;
         tick_cnt  <= '0;
         turn_q    <= 1'b0;
         fire_q    <= 1'b0;
         hit_q     <= 1'b0;
         over_q    <= 1'b0;
         power_q   <= '0;
         shell_q   <= '0;
         life1     <= 2'(LIVES);
         life2     <= 2'(LIVES);
      end else begin
         case (state)
            S_IDLE: begin
               if (k5_rise) begin
                  state    <= S_AIM;
                  tick_cnt <= '0;
               end
            end
            S_AIM: begin
               if (k4_rise) begin
                  state     <= S_CHARGE;
                  tick_cnt  <= '0;
                  power_lvl <= 4'd1;
                  power_q   <= therm(4'd1);
               end
            end
            // key_4 is high throughout CHARGE until its fall, so a tick alone charges
            S_CHARGE: begin
               if (k4_fall) begin
                  state    <= S_FLIGHT;
                  tick_cnt <= '0;
                  range_q  <= power_lvl;
                  step     <= '0;
                  fire_q   <= 1'b1;
                  shell_q  <= cell_onehot(turn_q, 4'd1);
               end else if (bus.tick) begin
                  power_lvl <= power_nx;
                  power_q   <= therm(power_nx);
               end
            end
            S_FLIGHT: begin
               if (bus.tick) begin
                  if (tick_cnt == 5'(FLIGHT_DIV - 1)) begin
                     tick_cnt <= '0;
                     step     <= step_nx;
                     if (step_nx == range_q) begin
                        state   <= S_IMPACT;
                        fire_q  <= 1'b0;
                        shell_q <= '0;
                        power_q <= '0;
                        hit_q   <= (range_q == 4'(TANK_DIST));
                        if (range_q == 4'(TANK_DIST)) begin
                           if (turn_q && life1 != 2'd0)
                              life1 <= life1 - 2'd1;
                           if (!turn_q && life2 != 2'd0)
                              life2 <= life2 - 2'd1;
                        end
                     end else begin
                        shell_q <= cell_onehot(turn_q, step_nx + 4'd1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 5'd1;
                  end
               end
            end
            S_IMPACT: begin
               if (bus.tick) begin
                  if (tick_cnt == 5'(IMPACT_TICKS - 1)) begin
                     tick_cnt <= '0;
                     hit_q    <= 1'b0;
                     if (opp_life == 2'd0) begin
                        state  <= S_OVER;
                        over_q <= 1'b1;
                     end else begin
                        state     <= S_AIM;
                        turn_q    <= ~turn_q;
                        power_lvl <= '0;
                        power_q   <= '0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 5'd1;
                  end
               end
            end
            S_OVER: begin
               state <= S_OVER;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.turn       = turn_q;
   assign bus.power      = power_q;
   assign bus.fire       = fire_q;
   assign bus.SHELL      = shell_q;
   assign bus.tank1_life = life1;
   assign bus.tank2_life = life2;
   assign bus.hit        = hit_q;
   assign bus.game_over  = over_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for the turn sequencer: turns, charging, flight, hits, game over.
module tb_turn_sequencer;

   logic clk;
   logic nrst;
   int   checks;
   int   failures;
   int   nt;

   turn_sequencer_if bus();

   turn_sequencer dut (
      .clk (clk),
      .nrst(nrst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         bus.tick = 1'b1;
         @(negedge clk);
         bus.tick = 1'b0;
         @(negedge clk);
      end
   endtask

   // press, charge for n ticks, release; flight begins two cycles later
   task automatic shoot(input int n);
      bus.key_4 = 1'b1;
      cyc(2);
      tick_n(n);
      bus.key_4 = 1'b0;
      cyc(2);
   endtask

   task automatic fly(output int n);
      n = 0;
      while (bus.fire && n < 64) begin
         tick_n(1);
         n++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      nrst      = 1'b0;
      bus.tick  = 1'b0;
      bus.key_4 = 1'b0;
      bus.key_5 = 1'b0;
      bus.key_6 = 1'b0;
      cyc(3);
      nrst = 1'b1;
      cyc(1);
      check("rst_turn", 32'(bus.turn), 32'd0);
      check("rst_power", 32'(bus.power), 32'h00);
      check("rst_fire", 32'(bus.fire), 32'd0);
      check("rst_shell", 32'(bus.SHELL), 32'h00);
      check("rst_hit", 32'(bus.hit), 32'd0);
      check("rst_over", 32'(bus.game_over), 32'd0);
      check("rst_life1", 32'(bus.tank1_life), 32'd3);
      check("rst_life2", 32'(bus.tank2_life), 32'd3);

      // key_4 in IDLE does nothing
      bus.key_4 = 1'b1;
      cyc(3);
      check("idle_k4", 32'(bus.power), 32'h00);
      bus.key_4 = 1'b0;
      cyc(3);

      bus.key_5 = 1'b1;
      cyc(2);
      bus.key_5 = 1'b0;

      // shot 1: turn 0, power 7, hit
      bus.key_4 = 1'b1;
      cyc(2);
      check("chg_start", 32'(bus.power), 32'h01);
      tick_n(6);
      check("chg_7", 32'(bus.power), 32'h7F);
      bus.key_4 = 1'b0;
      cyc(2);
      check("fl_fire", 32'(bus.fire), 32'd1);
      check("fl_power", 32'(bus.power), 32'h7F);
      for (int k = 1; k <= 7; k++) begin
         check($sformatf("walk%0d", k), 32'(bus.SHELL), 32'(8'd1 << k));
         tick_n(4);
      end
      check("imp_fire", 32'(bus.fire), 32'd0);
      check("imp_shell", 32'(bus.SHELL), 32'h00);
      check("imp_hit", 32'(bus.hit), 32'd1);
      check("imp_life2", 32'(bus.tank2_life), 32'd2);
      check("imp_power", 32'(bus.power), 32'h00);
      tick_n(15);
      check("imp_hold", 32'(bus.hit), 32'd1);
      tick_n(1);
      check("imp_end_hit", 32'(bus.hit), 32'd0);
      check("turn_to_1", 32'(bus.turn), 32'd1);

      // shot 2: turn 1, power 3, miss
      shoot(2);
      check("t1_power", 32'(bus.power), 32'h07);
      check("t1_c6", 32'(bus.SHELL), 32'h40);
      tick_n(4);
      check("t1_c5", 32'(bus.SHELL), 32'h20);
      tick_n(4);
      check("t1_c4", 32'(bus.SHELL), 32'h10);
      tick_n(4);
      check("t1_fire", 32'(bus.fire), 32'd0);
      check("t1_hit", 32'(bus.hit), 32'd0);
      check("t1_life1", 32'(bus.tank1_life), 32'd3);
      check("t1_life2", 32'(bus.tank2_life), 32'd2);
      tick_n(16);
      check("turn_to_0", 32'(bus.turn), 32'd0);

      // shot 3: 9 ticks wraps power to 2
      shoot(9);
      check("wrap_power", 32'(bus.power), 32'h03);
      fly(nt);
      check("wrap_flight", 32'(nt), 32'd8);
      check("wrap_hit", 32'(bus.hit), 32'd0);
      tick_n(16);
      check("turn_to_1b", 32'(bus.turn), 32'd1);

      // shot 4: release and tick in the same cycle at power 4
      bus.key_4 = 1'b1;
      cyc(2);
      tick_n(3);
      check("race_pre", 32'(bus.power), 32'h0F);
      bus.key_4 = 1'b0;
      cyc(1);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check("race_power", 32'(bus.power), 32'h0F);
      check("race_fire", 32'(bus.fire), 32'd1);
      tick_n(12);
      check("race_c3", 32'(bus.SHELL), 32'h08);
      tick_n(3);
      check("race_still", 32'(bus.fire), 32'd1);
      tick_n(1);
      check("race_land", 32'(bus.fire), 32'd0);
      tick_n(16);
      check("turn_to_0b", 32'(bus.turn), 32'd0);

      // tank2 takes its remaining two hits
      shoot(6);
      fly(nt);
      check("h2_flight", 32'(nt), 32'd28);
      check("h2_life2", 32'(bus.tank2_life), 32'd1);
      tick_n(16);
      shoot(0);
      fly(nt);
      check("miss_flight", 32'(nt), 32'd4);
      tick_n(16);
      shoot(6);
      fly(nt);
      check("h3_hit", 32'(bus.hit), 32'd1);
      check("h3_life2", 32'(bus.tank2_life), 32'd0);
      tick_n(16);
      check("over", 32'(bus.game_over), 32'd1);
      bus.key_4 = 1'b1;
      cyc(3);
      tick_n(3);
      bus.key_4 = 1'b0;
      cyc(3);
      check("over_k4_pw", 32'(bus.power), 32'h00);
      check("over_k4_fire", 32'(bus.fire), 32'd0);
      check("over_hold", 32'(bus.game_over), 32'd1);
      bus.key_6 = 1'b1;
      cyc(2);
      bus.key_6 = 1'b0;
      check("k6_over", 32'(bus.game_over), 32'd0);
      check("k6_life2", 32'(bus.tank2_life), 32'd3);
      check("k6_turn", 32'(bus.turn), 32'd0);

      // reset in the middle of a turn-1 flight
      bus.key_5 = 1'b1;
      cyc(2);
      bus.key_5 = 1'b0;
      shoot(0);
      fly(nt);
      tick_n(16);
      shoot(2);
      check("mid_fire", 32'(bus.fire), 32'd1);
      check("mid_turn", 32'(bus.turn), 32'd1);
      nrst = 1'b0;
      @(negedge clk);
      check("nrst_fire", 32'(bus.fire), 32'd0);
      check("nrst_shell", 32'(bus.SHELL), 32'h00);
      check("nrst_turn", 32'(bus.turn), 32'd0);
      nrst = 1'b1;
      bus.key_4 = 1'b1;
      cyc(3);
      check("nrst_idle", 32'(bus.power), 32'h00);
      bus.key_4 = 1'b0;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
